// File: rtl/tnn_neuron_accum.sv
// Ternary-neuron accumulate/threshold stage fed by pairs of 18-input popcounts.
// Sums (pos - neg) over up to MAX_CHUNKS beats, then emits a ternary activation
// together with the final sum through a valid/ready handshake.
// Optional build macro: TNN_ACC_SATURATE_EN selects a clamping accumulator
// (default build wraps at ACC_W bits).
module tnn_neuron_accum #(
    parameter int unsigned PC_W       = 5,
    parameter int unsigned ACC_W      = 10,
    parameter int          THR_HI     = 2,
    parameter int          THR_LO     = -2,
    parameter int unsigned MAX_CHUNKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pos,
    input  logic [PC_W-1:0]  in_neg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_trunc
);

    localparam int unsigned CNT_W = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CHUNKS - 1);
    localparam logic signed [ACC_W-1:0] THR_HI_A = ACC_W'(THR_HI);
    localparam logic signed [ACC_W-1:0] THR_LO_A = ACC_W'(THR_LO);
`ifdef TNN_ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   nxt_wide;
    logic signed [ACC_W-1:0] nxt;
    logic [CNT_W-1:0]        chunk_cnt;
    logic                    accept;
    logic                    final_beat;
    logic [1:0]              act_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: close an evaluation on its final beat, release on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (accept && final_beat) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)            state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // Handshake outputs decoded straight from the state flop
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Beat sum one bit wider than acc so the overflow is visible before wrap/clamp
    always_comb begin
        accept     = in_valid && in_ready;
        final_beat = in_last || (chunk_cnt == LAST_CNT);
        nxt_wide   = (ACC_W+1)'(acc) + (ACC_W+1)'(in_pos) - (ACC_W+1)'(in_neg);
`ifdef TNN_ACC_SATURATE_EN
        if (nxt_wide > (ACC_W+1)'(ACC_MAX)) begin
            nxt = ACC_MAX;
        end else if (nxt_wide < (ACC_W+1)'(ACC_MIN)) begin
            nxt = ACC_MIN;
        end else begin
            nxt = ACC_W'(nxt_wide);
        end
`else
        nxt = ACC_W'(nxt_wide);
`endif
        if (nxt > THR_HI_A) begin
            act_nxt = ACT_POS;
        end else if (nxt < THR_LO_A) begin
            act_nxt = ACT_NEG;
        end else begin
            act_nxt = ACT_ZERO;
        end
    end

    // Accumulator, beat counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            chunk_cnt <= '0;
            out_act   <= ACT_ZERO;
            out_sum   <= '0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            if (final_beat) begin
                acc       <= '0;
                chunk_cnt <= '0;
                out_sum   <= nxt;
                out_act   <= act_nxt;
                out_trunc <= ~in_last;
            end else begin
                acc       <= nxt;
                chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Directed bench for tnn_neuron_accum: default instance (ACC_W=10) plus a
// narrow instance (ACC_W=6) for the accumulator overflow case.
module tb_tnn_neuron_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_pos = '0;
    logic [4:0] in_neg = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_act;
    logic [9:0] out_sum;
    logic       out_trunc;

    logic       in_valid6 = 1'b0;
    logic       in_ready6;
    logic [4:0] in_pos6 = '0;
    logic [4:0] in_neg6 = '0;
    logic       in_last6 = 1'b0;
    logic       out_valid6;
    logic       out_ready6 = 1'b0;
    logic [1:0] out_act6;
    logic [5:0] out_sum6;
    logic       out_trunc6;

    int n_cmp = 0;
    int n_bad = 0;

    tnn_neuron_accum dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_act(out_act), .out_sum(out_sum), .out_trunc(out_trunc)
    );

    tnn_neuron_accum #(.ACC_W(6)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid6), .in_ready(in_ready6),
        .in_pos(in_pos6), .in_neg(in_neg6), .in_last(in_last6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_act(out_act6), .out_sum(out_sum6), .out_trunc(out_trunc6)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One beat on the default instance; inputs change on the falling edge
    task automatic send(input logic [4:0] p, input logic [4:0] n, input logic l);
        check_eq("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_pos   = p;
        in_neg   = n;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pos   = '0;
        in_neg   = '0;
    endtask

    // Check the pending result, then accept it
    task automatic take(input string tag, input logic [9:0] s, input logic [1:0] a, input logic t);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_sum"},   32'(out_sum),   32'(s));
        check_eq({tag, "_act"},   32'(out_act),   32'(a));
        check_eq({tag, "_trunc"}, 32'(out_trunc), 32'(t));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic send6(input logic [4:0] p, input logic [4:0] n, input logic l);
        in_valid6 = 1'b1;
        in_pos6   = p;
        in_neg6   = n;
        in_last6  = l;
        @(negedge clk);
        in_valid6 = 1'b0;
        in_last6  = 1'b0;
    endtask

    initial begin
        logic [5:0] exp6;

        // Reset with random beat traffic
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_pos   = 5'($urandom);
            in_neg   = 5'($urandom);
            @(negedge clk);
            check_eq("rst_out_valid", 32'(out_valid), 32'd0);
            check_eq("rst_out_act",   32'(out_act),   32'd0);
            check_eq("rst_out_sum",   32'(out_sum),   32'd0);
        end
        in_valid = 1'b0;
        in_pos   = '0;
        in_neg   = '0;
        rst      = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_trunc",    32'(out_trunc), 32'd0);

        // Single beat: 10 - 3 = 7
        send(5'd10, 5'd3, 1'b1);
        take("single", 10'd7, 2'b01, 1'b0);

        // Multi-beat: -4, -4, -3
        send(5'd5, 5'd9, 1'b0);
        send(5'd2, 5'd2, 1'b0);
        check_eq("multi_no_early_valid", 32'(out_valid), 32'd0);
        send(5'd1, 5'd0, 1'b1);
        take("multi", 10'h3FD, 2'b11, 1'b0);

        // Threshold boundaries
        send(5'd2, 5'd0, 1'b1);
        take("eq_hi", 10'd2, 2'b00, 1'b0);
        send(5'd0, 5'd2, 1'b1);
        take("eq_lo", 10'h3FE, 2'b00, 1'b0);
        send(5'd3, 5'd0, 1'b1);
        take("above_hi", 10'd3, 2'b01, 1'b0);

        // Idle gap inside an evaluation: 3 then -1 -> 2
        send(5'd3, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        send(5'd0, 5'd1, 1'b1);
        take("gap", 10'd2, 2'b00, 1'b0);

        // Backpressure: result held, beats offered meanwhile are ignored
        send(5'd6, 5'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_pos   = 5'd31;
            in_last  = 1'b1;
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready),  32'd0);
            check_eq("bp_valid",    32'(out_valid), 32'd1);
            check_eq("bp_sum",      32'(out_sum),   32'd5);
        end
        in_valid = 1'b0;
        in_pos   = '0;
        in_last  = 1'b0;
        take("bp", 10'd5, 2'b01, 1'b0);
        send(5'd0, 5'd1, 1'b1);
        take("after_bp", 10'h3FF, 2'b00, 1'b0);

        // Chunk limit closes the evaluation
        repeat (7) send(5'd1, 5'd0, 1'b0);
        check_eq("trunc_no_early_valid", 32'(out_valid), 32'd0);
        send(5'd1, 5'd0, 1'b0);
        take("trunc", 10'd8, 2'b01, 1'b1);

        // in_last coinciding with the chunk limit is not a truncation
        repeat (7) send(5'd1, 5'd0, 1'b0);
        send(5'd1, 5'd0, 1'b1);
        take("last_at_limit", 10'd8, 2'b01, 1'b0);

        // Reset mid-evaluation discards the partial sum
        repeat (3) send(5'd5, 5'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_valid",    32'(out_valid), 32'd0);
        check_eq("midrst_sum",      32'(out_sum),   32'd0);
        check_eq("midrst_act",      32'(out_act),   32'd0);
        check_eq("midrst_trunc",    32'(out_trunc), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready),  32'd1);
        send(5'd4, 5'd0, 1'b1);
        take("post_rst", 10'd4, 2'b01, 1'b0);

        // Reset while a result is pending drops it without a handshake
        send(5'd3, 5'd0, 1'b1);
        check_eq("hold_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("holdrst_valid", 32'(out_valid), 32'd0);
        check_eq("holdrst_sum",   32'(out_sum),   32'd0);
        send(5'd1, 5'd0, 1'b1);
        take("post_holdrst", 10'd1, 2'b00, 1'b0);

        // Overflow on the 6-bit accumulator: 31 + 31 + 31
`ifdef TNN_ACC_SATURATE_EN
        exp6 = 6'd31;
`else
        exp6 = 6'd29;
`endif
        check_eq("ovf_ready", 32'(in_ready6), 32'd1);
        send6(5'd31, 5'd0, 1'b0);
        send6(5'd31, 5'd0, 1'b0);
        send6(5'd31, 5'd0, 1'b1);
        check_eq("ovf_valid", 32'(out_valid6), 32'd1);
        check_eq("ovf_sum",   32'(out_sum6),   32'(exp6));
        check_eq("ovf_act",   32'(out_act6),   32'd1);
        check_eq("ovf_trunc", 32'(out_trunc6), 32'd0);
        out_ready6 = 1'b1;
        @(negedge clk);
        out_ready6 = 1'b0;
        check_eq("ovf_released", 32'(out_valid6), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tnn_neuron_accum.md
Name: tnn_neuron_accum

Overview:
- Sequential ternary-neuron stage directly downstream of the 18-input popcount units (exact or approximate; both produce 5-bit counts).
- Each beat carries two popcounts: inputs matched to +1 weights (pos) and to -1 weights (neg).
- Accumulates pos - neg across up to MAX_CHUNKS beats of a long input vector, then applies a ternary threshold activation.
- Emits the result through a valid/ready handshake to the next layer.

Parameters:
- PC_W, 5, width of each popcount input (unsigned).
- ACC_W, 10, width of the signed two's-complement accumulator and of out_sum.
- THR_HI, 2, signed upper threshold; sum > THR_HI gives +1.
- THR_LO, -2, signed lower threshold; sum < THR_LO gives -1. Requires THR_LO <= THR_HI.
- MAX_CHUNKS, 8, maximum beats per neuron evaluation (>= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  stage can accept a beat.
- in_pos  input  PC_W  popcount of +1-weighted inputs.
- in_neg  input  PC_W  popcount of -1-weighted inputs.
- in_last  input  1  final beat of the vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_act  output  2  ternary activation: 01 = +1, 11 = -1, 00 = 0.
- out_sum  output  ACC_W  final signed sum.
- out_trunc  output  1  evaluation closed by the MAX_CHUNKS limit rather than by in_last.

Behaviour:
- Reset values: state = ACC, acc = 0, chunk_cnt = 0, out_valid = 0, out_act = 00, out_sum = 0, out_trunc = 0. in_ready = 1 in the cycle after reset deasserts.
- rst is sampled on clk only. Asserting it mid-evaluation or while holding a result discards all state at that edge; no output handshake completes.
- State ACC:
  - in_ready = 1, out_valid = 0.
  - A beat is accepted when in_valid & in_ready.
  - Per accepted beat: nxt = acc + zext(in_pos) - zext(in_neg), computed at ACC_W+1 bits and then wrapped to ACC_W.
  - Non-final beat: acc <= nxt, chunk_cnt <= chunk_cnt + 1.
  - Final beat (in_last = 1, or chunk_cnt == MAX_CHUNKS-1): register out_sum = nxt and out_act from nxt; out_trunc = ~in_last; acc <= 0; chunk_cnt <= 0; go to HOLD.
  - in_last and the chunk limit on the same beat: out_trunc = 0.
- State HOLD:
  - out_valid = 1, in_ready = 0. in_valid and in_last are ignored.
  - out_act, out_sum and out_trunc are held stable until out_ready.
  - On out_ready: out_valid <= 0, go to ACC. The next beat can be accepted in the following cycle.
- Activation:
  - +1 if sum > THR_HI.
  - -1 if sum < THR_LO.
  - 0 otherwise, including sum == THR_HI and sum == THR_LO.
  - Comparison is signed at ACC_W.
- Latency: out_valid rises 1 cycle after the final beat is accepted.
- Throughput: at most one evaluation per (beats + 1) cycles when out_ready = 1. One bubble per evaluation, by design.
- in_pos and in_neg may take any PC_W value (up to 31). Approximate popcounts are not range-checked.
- in_valid low inside an evaluation: no effect; acc and chunk_cnt hold.

Optional Feature:
- Macro: TNN_ACC_SATURATE_EN.
- Defined: the nxt computation clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping. Clamping applies per beat, and acc holds the clamped value.
- Undefined: two's-complement wrap at ACC_W bits. This saves area in the printed flow.
- Activation and handshake are identical in both builds.

Test Plan:
- Reset: hold rst high 3 cycles with random in_valid -> out_valid = 0, out_act = 00, out_sum = 0; in_ready = 1 after release.
- Single beat: pos = 10, neg = 3, last = 1 -> next cycle out_valid = 1, out_sum = 7, out_act = 01, out_trunc = 0.
- Multi-beat: (5,9), (2,2), (1,0) with last on the third beat -> out_sum = -3, out_act = 11. Separately, a sum of exactly 2 -> out_act = 00.
- Backpressure: result pending, out_ready low 5 cycles while in_valid toggles -> in_ready = 0, outputs stable, no beats absorbed. The next evaluation starts from acc = 0.
- Truncation and reset: 8 beats of (1,0), never last -> out_sum = 8, out_act = 01, out_trunc = 1. Then assert rst after 3 beats of a new vector -> everything back to reset values, and a following single beat (4,0,last) -> out_sum = 4.
- Overflow with ACC_W = 6: 3 beats of (31,0), last on the third beat.
  - Macro defined -> out_sum = 31, out_act = 01.
  - Macro undefined -> out_sum = 29 (93 mod 64), out_act = 01.
